// File: rtl/frv_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port IDs, bus widths and
// the unlocked arbitration rule.
package frv_dmem_arbiter_pkg;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Pick a winner when no handshake is in progress. With nobody requesting
    // the choice is irrelevant, so port 0 is returned.
    function automatic logic arb_pick(
        input logic req0,
        input logic req1,
        input logic fixed_prio,
        input logic last
    );
        logic win;
        case ({req1, req0})
            2'b01:   win = ARB_P0;
            2'b10:   win = ARB_P1;
            2'b11:   win = fixed_prio ? ARB_P0 : ~last;
            default: win = ARB_P0;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/frv_arb_id_fifo.sv
// Owner-ID FIFO: remembers which port owns each accepted-but-unanswered
// memory transaction so in-order responses can be routed back.
module frv_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             push,
    input  logic             push_data,
    input  logic             pop,
    output logic             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] nxt;
        if (p == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = p + PTR_W'(1'b1);
        end
        return nxt;
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            mem_r    <= {DEPTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/frv_dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (LSU) and port 1 (secondary master)
// share one memory bus. Request arbitration and response routing are
// combinational; only lock, last-owner and the owner FIFO are registered.
module frv_dmem_arbiter
    import frv_dmem_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int FIXED_PRIO  = 0
) (
    input  logic              g_clk,
    input  logic              g_reset,

    input  logic              p0_req,
    input  logic              p0_wen,
    input  logic [STRB_W-1:0] p0_strb,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_gnt,
    output logic              p0_recv,
    input  logic              p0_ack,
    output logic              p0_error,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_wen,
    input  logic [STRB_W-1:0] p1_strb,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_gnt,
    output logic              p1_recv,
    input  logic              p1_ack,
    output logic              p1_error,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              m_req,
    output logic              m_wen,
    output logic [STRB_W-1:0] m_strb,
    output logic [DATA_W-1:0] m_wdata,
    output logic [ADDR_W-1:0] m_addr,
    input  logic              m_gnt,
    input  logic              m_recv,
    input  logic              m_error,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              m_ack,

    output logic              idle,
    output logic              spurious
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    logic             lock_r;
    logic             lock_id_r;
    logic             last_r;
    logic             pick_s;
    logic             sel_s;
    logic             sel_req_s;
    logic             grant_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic             head_s;
    logic [CNT_W-1:0] count_s;

    // While a request waits for m_gnt the owner is frozen so the memory-side
    // request cannot change mid-handshake.
    assign pick_s = arb_pick(p0_req, p1_req, (FIXED_PRIO != 0), last_r);
    assign sel_s  = lock_r ? lock_id_r : pick_s;

    // Route the selected port's request fields onto the memory bus.
    always_comb begin
        if (sel_s == ARB_P1) begin
            sel_req_s = p1_req;
            m_wen     = p1_wen;
            m_strb    = p1_strb;
            m_wdata   = p1_wdata;
            m_addr    = p1_addr;
        end else begin
            sel_req_s = p0_req;
            m_wen     = p0_wen;
            m_strb    = p0_strb;
            m_wdata   = p0_wdata;
            m_addr    = p0_addr;
        end
    end

    // A full FIFO blocks new requests; a pop in the same cycle does not bypass.
    assign m_req   = !g_reset && !full_s && sel_req_s;
    assign grant_s = m_req && m_gnt;
    assign p0_gnt  = grant_s && (sel_s == ARB_P0);
    assign p1_gnt  = grant_s && (sel_s == ARB_P1);

    // Steer the in-order response to the FIFO head's owner, or drain it when
    // nothing is outstanding.
    always_comb begin
        p0_recv  = 1'b0;
        p1_recv  = 1'b0;
        m_ack    = 1'b0;
        spurious = 1'b0;
        if (g_reset) begin
            m_ack    = 1'b0;
            spurious = 1'b0;
        end else if (!empty_s) begin
            if (head_s == ARB_P1) begin
                p1_recv = m_recv;
                m_ack   = p1_ack;
            end else begin
                p0_recv = m_recv;
                m_ack   = p0_ack;
            end
        end else begin
            m_ack    = m_recv;
            spurious = m_recv;
        end
    end

    // Read data and error are broadcast; recv alone qualifies them.
    assign p0_rdata = m_rdata;
    assign p1_rdata = m_rdata;
    assign p0_error = m_error;
    assign p1_error = m_error;

    assign pop_s = m_recv && m_ack && !empty_s;
    assign idle  = g_reset || ((count_s == {CNT_W{1'b0}}) && !m_req);

    // Lock the owner on a stalled request and remember the last grant for
    // round-robin; last resets to port 1 so port 0 wins the first conflict.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            lock_r    <= 1'b0;
            lock_id_r <= ARB_P0;
            last_r    <= ARB_P1;
        end else begin
            if (m_req && !m_gnt) begin
                lock_r    <= 1'b1;
                lock_id_r <= sel_s;
            end else if (grant_s) begin
                lock_r    <= 1'b0;
            end
            if (grant_s) begin
                last_r <= sel_s;
            end
        end
    end

    frv_arb_id_fifo #(
        .DEPTH (OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .push      (grant_s),
        .push_data (sel_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Randomised bench for frv_dmem_arbiter. Two instances (round-robin and
// fixed priority) run side by side, each with its own protocol-respecting
// requesters and memory, checked against a queue-based reference model.
module tb_frv_dmem_arbiter;
    import frv_dmem_arbiter_pkg::*;

    localparam int OUT = 2;
    localparam int NI  = 2;

    logic g_clk = 1'b0;
    logic g_reset = 1'b1;
    always #5 g_clk = ~g_clk;

    logic        p_req   [NI][2];
    logic        p_wen   [NI][2];
    logic [3:0]  p_strb  [NI][2];
    logic [31:0] p_wdata [NI][2];
    logic [31:0] p_addr  [NI][2];
    logic        p_ack   [NI][2];
    wire         p_gnt   [NI][2];
    wire         p_recv  [NI][2];
    wire         p_error [NI][2];
    wire  [31:0] p_rdata [NI][2];

    wire         m_req   [NI];
    wire         m_wen   [NI];
    wire  [3:0]  m_strb  [NI];
    wire  [31:0] m_wdata [NI];
    wire  [31:0] m_addr  [NI];
    logic        m_gnt   [NI];
    logic        m_recv  [NI];
    logic        m_error [NI];
    logic [31:0] m_rdata [NI];
    wire         m_ack   [NI];
    wire         idle    [NI];
    wire         spurious[NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        frv_dmem_arbiter #(.OUTSTANDING(OUT), .FIXED_PRIO(k)) u_dut (
            .g_clk    (g_clk),
            .g_reset  (g_reset),
            .p0_req   (p_req[k][0]),
            .p0_wen   (p_wen[k][0]),
            .p0_strb  (p_strb[k][0]),
            .p0_wdata (p_wdata[k][0]),
            .p0_addr  (p_addr[k][0]),
            .p0_gnt   (p_gnt[k][0]),
            .p0_recv  (p_recv[k][0]),
            .p0_ack   (p_ack[k][0]),
            .p0_error (p_error[k][0]),
            .p0_rdata (p_rdata[k][0]),
            .p1_req   (p_req[k][1]),
            .p1_wen   (p_wen[k][1]),
            .p1_strb  (p_strb[k][1]),
            .p1_wdata (p_wdata[k][1]),
            .p1_addr  (p_addr[k][1]),
            .p1_gnt   (p_gnt[k][1]),
            .p1_recv  (p_recv[k][1]),
            .p1_ack   (p_ack[k][1]),
            .p1_error (p_error[k][1]),
            .p1_rdata (p_rdata[k][1]),
            .m_req    (m_req[k]),
            .m_wen    (m_wen[k]),
            .m_strb   (m_strb[k]),
            .m_wdata  (m_wdata[k]),
            .m_addr   (m_addr[k]),
            .m_gnt    (m_gnt[k]),
            .m_recv   (m_recv[k]),
            .m_error  (m_error[k]),
            .m_rdata  (m_rdata[k]),
            .m_ack    (m_ack[k]),
            .idle     (idle[k]),
            .spurious (spurious[k])
        );
    end

    // Reference model state: outstanding owners in order, plus the
    // "pending owner" of a stalled request and the owner of the last grant.
    bit   mq      [NI][$];
    logic mlock   [NI];
    logic mlock_id[NI];
    logic mlast   [NI];

    // Expectations for the current cycle
    logic e_sel  [NI];
    logic e_mreq [NI];
    logic e_gnt  [NI][2];
    logic e_mack [NI];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Randomise inputs while honouring the hold-until-handshake rules.
    task automatic drive(input int k, input int req_pct, input int gnt_pct,
                         input int recv_pct, input int ack_pct);
        for (int n = 0; n < 2; n++) begin
            if (!(p_req[k][n] && !e_gnt[k][n])) begin
                p_req[k][n]   = ($urandom_range(99, 0) < req_pct);
                p_wen[k][n]   = 1'($urandom);
                p_strb[k][n]  = 4'($urandom);
                p_wdata[k][n] = $urandom;
                p_addr[k][n]  = $urandom;
            end
            p_ack[k][n] = ($urandom_range(99, 0) < ack_pct);
        end
        m_gnt[k] = ($urandom_range(99, 0) < gnt_pct);
        if (!(m_recv[k] && !e_mack[k])) begin
            m_recv[k]  = (mq[k].size() > 0) ? ($urandom_range(99, 0) < recv_pct)
                                            : ($urandom_range(99, 0) < 5);
            m_rdata[k] = $urandom;
            m_error[k] = ($urandom_range(7, 0) == 0);
        end
    endtask

    // Compute what the arbiter must show this cycle and compare.
    task automatic eval_cycle(input int k);
        logic s;
        logic h;
        logic full;
        logic e_recv [2];
        logic e_spur;
        string pfx;
        pfx = $sformatf("i%0d.", k);
        if (g_reset) begin
            e_mreq[k] = 1'b0;
            e_gnt[k][0] = 1'b0;
            e_gnt[k][1] = 1'b0;
            e_mack[k] = 1'b0;
            check_val({pfx, "rst.m_req"}, 32'(m_req[k]), 32'd0);
            check_val({pfx, "rst.m_ack"}, 32'(m_ack[k]), 32'd0);
            check_val({pfx, "rst.gnt"}, 32'({p_gnt[k][1], p_gnt[k][0]}), 32'd0);
            check_val({pfx, "rst.recv"}, 32'({p_recv[k][1], p_recv[k][0]}), 32'd0);
            check_val({pfx, "rst.spurious"}, 32'(spurious[k]), 32'd0);
            check_val({pfx, "rst.idle"}, 32'(idle[k]), 32'd1);
        end else begin
            full = (mq[k].size() >= OUT);
            if (mlock[k]) begin
                s = mlock_id[k];
            end else if (p_req[k][0] && p_req[k][1]) begin
                s = (k == 1) ? 1'b0 : !mlast[k];
            end else begin
                s = p_req[k][1];
            end
            e_sel[k]  = s;
            e_mreq[k] = !full && p_req[k][s];
            for (int n = 0; n < 2; n++) begin
                e_gnt[k][n] = e_mreq[k] && m_gnt[k] && (int'(s) == n);
                e_recv[n]   = 1'b0;
            end
            if (mq[k].size() > 0) begin
                h = mq[k][0];
                e_recv[h] = m_recv[k];
                e_mack[k] = p_ack[k][h];
                e_spur    = 1'b0;
            end else begin
                e_mack[k] = m_recv[k];
                e_spur    = m_recv[k];
            end
            check_val({pfx, "m_req"}, 32'(m_req[k]), 32'(e_mreq[k]));
            check_val({pfx, "p0_gnt"}, 32'(p_gnt[k][0]), 32'(e_gnt[k][0]));
            check_val({pfx, "p1_gnt"}, 32'(p_gnt[k][1]), 32'(e_gnt[k][1]));
            check_val({pfx, "p0_recv"}, 32'(p_recv[k][0]), 32'(e_recv[0]));
            check_val({pfx, "p1_recv"}, 32'(p_recv[k][1]), 32'(e_recv[1]));
            check_val({pfx, "m_ack"}, 32'(m_ack[k]), 32'(e_mack[k]));
            check_val({pfx, "spurious"}, 32'(spurious[k]), 32'(e_spur));
            check_val({pfx, "idle"}, 32'(idle[k]),
                      32'((mq[k].size() == 0) && !e_mreq[k]));
            if (e_mreq[k]) begin
                check_val({pfx, "m_addr"}, m_addr[k], p_addr[k][s]);
                check_val({pfx, "m_wdata"}, m_wdata[k], p_wdata[k][s]);
                check_val({pfx, "m_wen"}, 32'(m_wen[k]), 32'(p_wen[k][s]));
                check_val({pfx, "m_strb"}, 32'(m_strb[k]), 32'(p_strb[k][s]));
            end
            for (int n = 0; n < 2; n++) begin
                if (e_recv[n]) begin
                    check_val($sformatf("%sp%0d_rdata", pfx, n), p_rdata[k][n], m_rdata[k]);
                    check_val($sformatf("%sp%0d_error", pfx, n), 32'(p_error[k][n]),
                              32'(m_error[k]));
                end
            end
        end
    endtask

    // Advance the model across the clock edge.
    task automatic update(input int k);
        logic grant;
        if (g_reset) begin
            mq[k].delete();
            mlock[k] = 1'b0;
            mlock_id[k] = 1'b0;
            mlast[k] = 1'b1;
        end else begin
            grant = e_mreq[k] && m_gnt[k];
            if (e_mreq[k] && !m_gnt[k]) begin
                mlock[k]    = 1'b1;
                mlock_id[k] = e_sel[k];
            end else if (grant) begin
                mlock[k] = 1'b0;
            end
            if (m_recv[k] && e_mack[k] && (mq[k].size() > 0)) begin
                void'(mq[k].pop_front());
            end
            if (grant) begin
                mlast[k] = e_sel[k];
                mq[k].push_back(e_sel[k]);
            end
        end
    endtask

    task automatic run_cycle(input logic rst, input int req_pct, input int gnt_pct,
                             input int recv_pct, input int ack_pct);
        @(negedge g_clk);
        g_reset = rst;
        for (int k = 0; k < NI; k++) drive(k, req_pct, gnt_pct, recv_pct, ack_pct);
        #1;
        for (int k = 0; k < NI; k++) eval_cycle(k);
        @(posedge g_clk);
        for (int k = 0; k < NI; k++) update(k);
    endtask

    // {req%, gnt%, recv%, ack%, cycles}
    int phases [5][5] = '{
        '{100, 100, 100, 100, 200},
        '{ 60,  30,  50,  60, 600},
        '{ 90,  70,  20,  40, 600},
        '{ 30,  50,  80,  30, 600},
        '{ 95,  20,  60,  80, 600}
    };

    initial begin
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 2; n++) begin
                p_req[k][n] = 1'b0; p_wen[k][n] = 1'b0; p_strb[k][n] = 4'd0;
                p_wdata[k][n] = 32'd0; p_addr[k][n] = 32'd0; p_ack[k][n] = 1'b0;
                e_gnt[k][n] = 1'b0;
            end
            m_gnt[k] = 1'b0; m_recv[k] = 1'b0; m_error[k] = 1'b0; m_rdata[k] = 32'd0;
            e_mack[k] = 1'b0; e_mreq[k] = 1'b0; e_sel[k] = 1'b0;
            mlock[k] = 1'b0; mlock_id[k] = 1'b0; mlast[k] = 1'b1;
        end
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 3; c++) begin
                run_cycle(1'b1, phases[p][0], phases[p][1], phases[p][2], phases[p][3]);
            end
            for (int c = 0; c < phases[p][4]; c++) begin
                run_cycle(1'b0, phases[p][0], phases[p][1], phases[p][2], phases[p][3]);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
